// File: rtl/serial_subtractor.sv
// Purpose: bit-serial a - b - bin, one full-subtractor cell plus a borrow flop, LSB first.
// Latency: done pulses WIDTH edges after the edge that accepts start; one op per WIDTH+1 cycles back-to-back.
// Backpressure: start is only accepted in IDLE or DONE; start while busy is ignored.

// Purpose: single-bit full subtractor, d = a - b - bin, borrow out on bo.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             dbit,
    output logic             dbit_valid
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic           br;

    logic           cell_d;
    logic           cell_bo;
    logic           last_bit;
    logic [WIDTH-1:0] res_next;

    // The cell always looks at the current LSBs and the running borrow.
    full_subtractor u_cell (
        .a   (sa[0]),
        .b   (sb[0]),
        .bin (br),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // New difference bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {cell_d, res[WIDTH-1:1]};

    // Control FSM and datapath; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            br         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            bout       <= 1'b0;
            dbit       <= 1'b0;
            dbit_valid <= 1'b0;
        end else begin
            done       <= 1'b0;
            dbit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    dbit       <= cell_d;
                    dbit_valid <= 1'b1;
                    res        <= res_next;
                    sa         <= sa >> 1;
                    sb         <= sb >> 1;
                    br         <= cell_bo;
                    if (last_bit) begin
                        // diff/bout are only refreshed here, so they hold across the next op.
                        diff  <= res_next;
                        bout  <= cell_bo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // A start on the leaving edge chains straight into the next op.
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor computing diff = a - b - bin over WIDTH clock cycles, LSB first.
- Uses one full-subtractor cell and a borrow flip-flop. It is the arithmetic inverse of the team's full-adder cell.
- Sits beside the adder datapath as a low-area, multi-cycle subtract unit with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on rising clk edge when accepting
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: diff/bout valid
diff  output  WIDTH  result, held until next completion
bout  output  1  final borrow-out, held until next completion
dbit  output  1  serial difference bit produced this cycle
dbit_valid  output  1  high in cycles where dbit is meaningful

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, diff=0, bout=0, dbit=0, dbit_valid=0, bit counter=0, borrow reg=0, operand shift regs=0.
- States:
  - IDLE: busy=0. start=1 at edge -> capture a, b, bin into shift regs/borrow reg; counter=0; go SHIFT.
  - SHIFT: busy=1. Each edge processes the LSBs:
    - d = a0 ^ b0 ^ br
    - bo = (~a0 & b0) | (~(a0 ^ b0) & br)
    - d shifts into the result reg at the MSB end; operand regs shift right; br = bo; counter increments.
    - On the edge processing bit WIDTH-1: diff <= full result, bout <= bo; go DONE.
  - DONE: done=1, busy=0, lasts exactly one cycle.
    - start=1 at the leaving edge -> accepted as in IDLE (back-to-back), go SHIFT.
    - Otherwise go IDLE.
- Serial output: dbit/dbit_valid are registered.
  - dbit_valid=1 in the cycle after each SHIFT edge: WIDTH consecutive cycles, the last of which coincides with done.
  - dbit carries bit i in the i-th of those cycles.
- Latency: done rises exactly WIDTH edges after the edge that accepted start. Throughput is one operation per WIDTH+1 cycles (back-to-back).
- start while in SHIFT: ignored, no effect on captured operands. a, b, bin are don't-care after capture.
- diff/bout change only on the final SHIFT edge. They stay stable through IDLE and through the next operation until its completion.
- Arithmetic: result is modulo 2^WIDTH. bout=1 iff a < b + bin (unsigned), i.e. the two's-complement wrap.
- Reset mid-operation: abort immediately; all outputs take reset values; no done pulse. The next start after rst deasserts is handled normally.
- Counter width: clog2(WIDTH); no wrap beyond WIDTH-1.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0 -> done 8 edges after start; diff=0x02, bout=0; dbit sequence LSB-first 0,1,0,0,0,0,0,0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0; a=0x80, b=0x01, bin=1 -> diff=0x7E, bout=0.
- Start op (0x10-0x01), pulse start with a=0xAA, b=0x55 on cycle 3 of SHIFT -> ignored; diff=0x0F, bout=0; busy width exactly 8 cycles.
- Assert rst at cycle 4 of SHIFT -> busy/done/diff/bout=0 same cycle, no done pulse; restart with 0x09-0x04 -> diff=0x05.
- Back-to-back: start held high across DONE -> second op begins, done pulses every 9 cycles; self-check all 512 combos for WIDTH=4 (a, b, bin) against a - b - bin.
